// File: rtl/shared_counter_arbiter_pkg.sv
// shared_counter_arbiter_pkg: FSM state encoding and default sizes for the shared counter arbiter
package shared_counter_arbiter_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    COUNT = 2'b01,
    DONE  = 2'b10
  } state_t;
  localparam int NREQ_DEF  = 4;
  localparam int WIDTH_DEF = 4;
endpackage

// File: rtl/shared_counter_arbiter_pick.sv
// rr_arb_pick: round-robin pick of the first set req bit after ptr (mod N); outputs one-hot win, its index idx, and any
module rr_arb_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  win,
  output logic [PW-1:0] idx,
  output logic          any
);
  assign any = |req;
  always_comb begin
    win = '0;
    idx = '0;
    for (int k = N; k >= 1; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        win = '0;
        win[(int'(ptr) + k) % N] = 1'b1;
        idx = PW'((int'(ptr) + k) % N);
      end
    end
  end
endmodule

// File: rtl/shared_counter_arbiter.sv
// shared_counter_arbiter: round-robin sharing of one up-counter; req/len in, one-hot gnt, busy, counter Q, one-hot done out
module shared_counter_arbiter
  import shared_counter_arbiter_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] len,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic [WIDTH-1:0]      Q,
  output logic [NREQ-1:0]       done
);
  localparam int PW = NREQ > 1 ? $clog2(NREQ) : 1;
  state_t state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] idx;
  logic [NREQ-1:0] win;
  logic any;
  logic [WIDTH-1:0] term;
  rr_arb_pick #(.N(NREQ), .PW(PW)) u_pick (
    .req(req),
    .ptr(ptr),
    .win(win),
    .idx(idx),
    .any(any)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= PW'(NREQ - 1);
      term  <= '0;
      gnt   <= '0;
      Q     <= '0;
    end else begin
      case (state)
        IDLE: if (any) begin
          gnt   <= win;
          term  <= len[int'(idx)*WIDTH +: WIDTH];
          ptr   <= idx;
          Q     <= '0;
          state <= COUNT;
        end
        COUNT: if (Q == term) state <= DONE;
               else Q <= Q + 1'b1;
        DONE: begin
          gnt   <= '0;
          Q     <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign busy = state != IDLE;
  assign done = state == DONE ? gnt : '0;
endmodule

// File: tb/tb_shared_counter_arbiter.sv
// tb_shared_counter_arbiter: directed checks of {gnt,busy,Q,done} cycle by cycle against hand-computed values
module tb_shared_counter_arbiter;
  logic clk = 1'b1;
  logic reset;
  logic [3:0] req;
  logic [15:0] len;
  logic [3:0] gnt;
  logic busy;
  logic [3:0] Q;
  logic [3:0] done;
  int errors = 0;
  int checks = 0;

  shared_counter_arbiter #(.NREQ(4), .WIDTH(4)) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .len(len),
    .gnt(gnt),
    .busy(busy),
    .Q(Q),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req = '0;
    len = '0;
    step();
    step();
    checks++;
    if ({gnt, busy, Q, done} !== {4'b0000, 1'b0, 4'd0, 4'b0000}) begin
      errors++;
      $display("FAIL reset_state got=%h exp=%h", {gnt, busy, Q, done}, 13'h0);
    end
    reset = 1'b0;
    step();
    checks++;
    if ({gnt, busy, Q, done} !== {4'b0000, 1'b0, 4'd0, 4'b0000}) begin
      errors++;
      $display("FAIL reset_release got=%h exp=%h", {gnt, busy, Q, done}, 13'h0);
    end
  endtask

  task automatic test_single();
    req = 4'b0100;
    len = '0;
    len[8 +: 4] = 4'd3;
    step();
    req = '0;
    for (int i = 0; i <= 3; i++) begin
      checks++;
      if ({gnt, busy, Q, done} !== {4'b0100, 1'b1, 4'(i), 4'b0000}) begin
        errors++;
        $display("FAIL single_count%0d got=%h exp=%h", i, {gnt, busy, Q, done}, {4'b0100, 1'b1, 4'(i), 4'b0000});
      end
      step();
    end
    checks++;
    if ({gnt, busy, Q, done} !== {4'b0100, 1'b1, 4'd3, 4'b0100}) begin
      errors++;
      $display("FAIL single_done got=%h exp=%h", {gnt, busy, Q, done}, {4'b0100, 1'b1, 4'd3, 4'b0100});
    end
    step();
    checks++;
    if ({gnt, busy, Q, done} !== {4'b0000, 1'b0, 4'd0, 4'b0000}) begin
      errors++;
      $display("FAIL single_idle got=%h exp=%h", {gnt, busy, Q, done}, 13'h0);
    end
  endtask

  task automatic test_contention();
    logic [3:0] e;
    reset = 1'b1;
    step();
    reset = 1'b0;
    req = 4'b1111;
    len = 16'h1111;
    step();
    for (int k = 0; k < 5; k++) begin
      e = 4'b0001 << (k % 4);
      checks++;
      if ({gnt, busy, Q, done} !== {e, 1'b1, 4'd0, 4'b0000}) begin
        errors++;
        $display("FAIL rr_grant%0d got=%h exp=%h", k, {gnt, busy, Q, done}, {e, 1'b1, 4'd0, 4'b0000});
      end
      step();
      checks++;
      if ({gnt, busy, Q, done} !== {e, 1'b1, 4'd1, 4'b0000}) begin
        errors++;
        $display("FAIL rr_count%0d got=%h exp=%h", k, {gnt, busy, Q, done}, {e, 1'b1, 4'd1, 4'b0000});
      end
      step();
      checks++;
      if ({gnt, busy, Q, done} !== {e, 1'b1, 4'd1, e}) begin
        errors++;
        $display("FAIL rr_done%0d got=%h exp=%h", k, {gnt, busy, Q, done}, {e, 1'b1, 4'd1, e});
      end
      step();
      checks++;
      if ({gnt, busy, Q, done} !== {4'b0000, 1'b0, 4'd0, 4'b0000}) begin
        errors++;
        $display("FAIL rr_idle%0d got=%h exp=%h", k, {gnt, busy, Q, done}, 13'h0);
      end
      if (k == 4) req = '0;
      step();
    end
  endtask

  task automatic test_zero_len();
    req = 4'b0001;
    len = 16'hFFF0;
    step();
    req = '0;
    checks++;
    if ({gnt, busy, Q, done} !== {4'b0001, 1'b1, 4'd0, 4'b0000}) begin
      errors++;
      $display("FAIL zero_count got=%h exp=%h", {gnt, busy, Q, done}, {4'b0001, 1'b1, 4'd0, 4'b0000});
    end
    step();
    checks++;
    if ({gnt, busy, Q, done} !== {4'b0001, 1'b1, 4'd0, 4'b0001}) begin
      errors++;
      $display("FAIL zero_done got=%h exp=%h", {gnt, busy, Q, done}, {4'b0001, 1'b1, 4'd0, 4'b0001});
    end
    step();
    checks++;
    if ({gnt, busy, Q, done} !== {4'b0000, 1'b0, 4'd0, 4'b0000}) begin
      errors++;
      $display("FAIL zero_idle got=%h exp=%h", {gnt, busy, Q, done}, 13'h0);
    end
  endtask

  task automatic test_reset_mid();
    req = 4'b0010;
    len = '0;
    len[4 +: 4] = 4'd9;
    step();
    req = '0;
    for (int i = 0; i < 5; i++) step();
    checks++;
    if ({gnt, busy, Q, done} !== {4'b0010, 1'b1, 4'd5, 4'b0000}) begin
      errors++;
      $display("FAIL mid_q5 got=%h exp=%h", {gnt, busy, Q, done}, {4'b0010, 1'b1, 4'd5, 4'b0000});
    end
    reset = 1'b1;
    step();
    checks++;
    if ({gnt, busy, Q, done} !== {4'b0000, 1'b0, 4'd0, 4'b0000}) begin
      errors++;
      $display("FAIL mid_abort got=%h exp=%h", {gnt, busy, Q, done}, 13'h0);
    end
    reset = 1'b0;
    req = 4'b1111;
    len = '0;
    step();
    req = '0;
    checks++;
    if ({gnt, busy, Q, done} !== {4'b0001, 1'b1, 4'd0, 4'b0000}) begin
      errors++;
      $display("FAIL mid_regrant got=%h exp=%h", {gnt, busy, Q, done}, {4'b0001, 1'b1, 4'd0, 4'b0000});
    end
    step();
    step();
    checks++;
    if ({gnt, busy, Q, done} !== {4'b0000, 1'b0, 4'd0, 4'b0000}) begin
      errors++;
      $display("FAIL mid_idle got=%h exp=%h", {gnt, busy, Q, done}, 13'h0);
    end
  endtask

  task automatic test_req_drop();
    req = 4'b1000;
    len = '0;
    len[12 +: 4] = 4'd4;
    step();
    checks++;
    if ({gnt, busy, Q, done} !== {4'b1000, 1'b1, 4'd0, 4'b0000}) begin
      errors++;
      $display("FAIL drop_grant got=%h exp=%h", {gnt, busy, Q, done}, {4'b1000, 1'b1, 4'd0, 4'b0000});
    end
    step();
    step();
    checks++;
    if ({gnt, busy, Q, done} !== {4'b1000, 1'b1, 4'd2, 4'b0000}) begin
      errors++;
      $display("FAIL drop_q2 got=%h exp=%h", {gnt, busy, Q, done}, {4'b1000, 1'b1, 4'd2, 4'b0000});
    end
    req = '0;
    len = '0;
    step();
    step();
    checks++;
    if ({gnt, busy, Q, done} !== {4'b1000, 1'b1, 4'd4, 4'b0000}) begin
      errors++;
      $display("FAIL drop_q4 got=%h exp=%h", {gnt, busy, Q, done}, {4'b1000, 1'b1, 4'd4, 4'b0000});
    end
    step();
    checks++;
    if ({gnt, busy, Q, done} !== {4'b1000, 1'b1, 4'd4, 4'b1000}) begin
      errors++;
      $display("FAIL drop_done got=%h exp=%h", {gnt, busy, Q, done}, {4'b1000, 1'b1, 4'd4, 4'b1000});
    end
    step();
    checks++;
    if ({gnt, busy, Q, done} !== {4'b0000, 1'b0, 4'd0, 4'b0000}) begin
      errors++;
      $display("FAIL drop_idle got=%h exp=%h", {gnt, busy, Q, done}, 13'h0);
    end
    step();
    checks++;
    if ({gnt, busy, Q, done} !== {4'b0000, 1'b0, 4'd0, 4'b0000}) begin
      errors++;
      $display("FAIL drop_stay got=%h exp=%h", {gnt, busy, Q, done}, 13'h0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_zero_len();
    test_reset_mid();
    test_req_drop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
